// File: rtl/vfu_pkg.sv
// Shared types and widths for the CPU-to-Vfu command path.
package vfu_pkg;

  localparam int VFU_RND_W = 3;
  localparam int VFU_CMD_W = 99;

  typedef struct packed {
    logic [31:0]          instruction;
    logic [31:0]          inputs_0;
    logic [31:0]          inputs_1;
    logic [VFU_RND_W-1:0] rounding;
  } vfu_cmd_t;

endpackage

// File: rtl/vfu_cmd_store.sv
// Command storage: DEPTH x VFU_CMD_W registers, one write port,
// one asynchronous read port, asynchronous clear of every entry.
module vfu_cmd_store
  import vfu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [VFU_CMD_W-1:0] wdata,
  input  logic [AW-1:0]        raddr,
  output logic [VFU_CMD_W-1:0] rdata
);

  logic [VFU_CMD_W-1:0] mem [DEPTH];

  // Write one entry per cycle; reset wipes all entries so stale data reads as zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Head entry is read straight out of the register array.
  always_comb begin
    rdata = mem[raddr];
  end

endmodule

// File: rtl/vfu_cmd_fifo.sv
// Command FIFO between the CPU custom-instruction port and the Vfu cmd port.
// cmd_ready depends only on registered occupancy.
// Optional macro VFU_CMD_FIFO_BYPASS_EN: when empty and the Vfu is ready,
// an incoming command passes straight through in the same cycle without
// being stored.
module vfu_cmd_fifo
  import vfu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_payload_instruction,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  input  logic [2:0]  cmd_payload_rounding,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_payload_instruction,
  output logic [31:0] out_payload_inputs_0,
  output logic [31:0] out_payload_inputs_1,
  output logic [2:0]  out_payload_rounding,
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             empty;
  logic             bypass;
  logic             push;
  logic             pop;
  vfu_cmd_t         cmd_in;
  vfu_cmd_t         head;
  vfu_cmd_t         out_cmd;
  logic [VFU_CMD_W-1:0] head_raw;

  // Pack the incoming command into the stored record.
  always_comb begin
    cmd_in.instruction = cmd_payload_instruction;
    cmd_in.inputs_0    = cmd_payload_inputs_0;
    cmd_in.inputs_1    = cmd_payload_inputs_1;
    cmd_in.rounding    = cmd_payload_rounding;
  end

  // Handshake decode; ready comes only from the registered level.
  always_comb begin
    full      = (level == LVL_W'(DEPTH));
    empty     = (level == '0);
    cmd_ready = !full;
`ifdef VFU_CMD_FIFO_BYPASS_EN
    bypass    = empty && cmd_valid && out_ready;
`else
    bypass    = 1'b0;
`endif
    push      = cmd_valid && cmd_ready && !bypass;
    pop       = !empty && out_ready;
    out_valid = !empty || bypass;
  end

  vfu_cmd_store #(
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_store (
    .clk   (clk),
    .reset (reset),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (cmd_in),
    .raddr (rd_ptr),
    .rdata (head_raw)
  );

  // Select the head entry or, in the pass-through case, the live command.
  always_comb begin
    head = vfu_cmd_t'(head_raw);
`ifdef VFU_CMD_FIFO_BYPASS_EN
    out_cmd = bypass ? cmd_in : head;
`else
    out_cmd = head;
`endif
    out_payload_instruction = out_cmd.instruction;
    out_payload_inputs_0    = out_cmd.inputs_0;
    out_payload_inputs_1    = out_cmd.inputs_1;
    out_payload_rounding    = out_cmd.rounding;
  end

  // Pointers wrap naturally at DEPTH; level is tracked separately so full and empty are unambiguous.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_vfu_cmd_fifo.sv
// Directed bench for vfu_cmd_fifo (DEPTH = 4), covers both bypass builds.
module tb_vfu_cmd_fifo;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_payload_instruction;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic [2:0]  cmd_payload_rounding;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_payload_instruction;
  logic [31:0] out_payload_inputs_0;
  logic [31:0] out_payload_inputs_1;
  logic [2:0]  out_payload_rounding;
  logic [2:0]  level;

  int tests;
  int fails;

  vfu_cmd_fifo #(.DEPTH(4)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_instruction (cmd_payload_instruction),
    .cmd_payload_inputs_0    (cmd_payload_inputs_0),
    .cmd_payload_inputs_1    (cmd_payload_inputs_1),
    .cmd_payload_rounding    (cmd_payload_rounding),
    .out_valid               (out_valid),
    .out_ready               (out_ready),
    .out_payload_instruction (out_payload_instruction),
    .out_payload_inputs_0    (out_payload_inputs_0),
    .out_payload_inputs_1    (out_payload_inputs_1),
    .out_payload_rounding    (out_payload_rounding),
    .level                   (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] r);
    cmd_valid               = v;
    cmd_payload_instruction = ins;
    cmd_payload_inputs_0    = a;
    cmd_payload_inputs_1    = b;
    cmd_payload_rounding    = r;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 3'd0);
    #2;
    tests++;
    if (cmd_ready !== 1'b1 || out_valid !== 1'b0 || level !== 3'd0) begin
      fails++;
      $display("FAIL reset_ctrl: cmd_ready=%b out_valid=%b level=%0d, want 1 0 0", cmd_ready, out_valid, level);
    end
    tests++;
    if (out_payload_instruction !== 32'h0 || out_payload_inputs_0 !== 32'h0 ||
        out_payload_inputs_1 !== 32'h0 || out_payload_rounding !== 3'd0) begin
      fails++;
      $display("FAIL reset_payload: instr=%h in0=%h in1=%h rnd=%0d, want all 0",
               out_payload_instruction, out_payload_inputs_0, out_payload_inputs_1, out_payload_rounding);
    end
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_single();
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_0001, 32'h11, 32'h22, 3'd3);
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 3'd0);
    tests++;
    if (out_valid !== 1'b1 || level !== 3'd1 || out_payload_instruction !== 32'h1 ||
        out_payload_inputs_0 !== 32'h11 || out_payload_inputs_1 !== 32'h22 || out_payload_rounding !== 3'd3) begin
      fails++;
      $display("FAIL single_push: valid=%b level=%0d instr=%h in0=%h in1=%h rnd=%0d, want 1 1 1 11 22 3",
               out_valid, level, out_payload_instruction, out_payload_inputs_0, out_payload_inputs_1, out_payload_rounding);
    end
    step();
    tests++;
    if (out_valid !== 1'b1 || out_payload_inputs_0 !== 32'h11) begin
      fails++;
      $display("FAIL single_hold: valid=%b in0=%h, want 1 11", out_valid, out_payload_inputs_0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || level !== 3'd0) begin
      fails++;
      $display("FAIL single_pop: valid=%b level=%0d, want 0 0", out_valid, level);
    end
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hA0 + 32'(i), 32'h0, 32'h0, 3'd0);
      step();
    end
    tests++;
    if (cmd_ready !== 1'b0 || level !== 3'd4) begin
      fails++;
      $display("FAIL fill_full: cmd_ready=%b level=%0d, want 0 4", cmd_ready, level);
    end
    drive(1'b1, 32'hFF, 32'h0, 32'h0, 3'd0);
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 3'd0);
    tests++;
    if (level !== 3'd4 || out_payload_instruction !== 32'hA0) begin
      fails++;
      $display("FAIL fill_ignore5: level=%0d head=%h, want 4 a0", level, out_payload_instruction);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (out_valid !== 1'b1 || out_payload_instruction !== 32'hA0 + 32'(i)) begin
        fails++;
        $display("FAIL fill_drain[%0d]: valid=%b instr=%h, want 1 %h", i, out_valid, out_payload_instruction, 32'hA0 + 32'(i));
      end
      step();
    end
    out_ready = 1'b0;
    tests++;
    if (level !== 3'd0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL fill_empty: level=%0d valid=%b, want 0 0", level, out_valid);
    end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 32'(i), 32'h0, 32'h0, 3'd0);
      #1;
`ifdef VFU_CMD_FIFO_BYPASS_EN
      tests++;
      if (out_valid !== 1'b1 || out_payload_instruction !== 32'(i) || level !== 3'd0) begin
        fails++;
        $display("FAIL stream[%0d]: valid=%b instr=%h level=%0d, want 1 %h 0", i, out_valid, out_payload_instruction, level, i);
      end
`else
      if (i > 0) begin
        tests++;
        if (out_valid !== 1'b1 || out_payload_instruction !== 32'(i - 1) || level !== 3'd1) begin
          fails++;
          $display("FAIL stream[%0d]: valid=%b instr=%h level=%0d, want 1 %h 1", i, out_valid, out_payload_instruction, level, i - 1);
        end
      end
`endif
      step();
    end
    drive(1'b0, 32'h0, 32'h0, 32'h0, 3'd0);
`ifndef VFU_CMD_FIFO_BYPASS_EN
    tests++;
    if (out_valid !== 1'b1 || out_payload_instruction !== 32'd15) begin
      fails++;
      $display("FAIL stream_last: valid=%b instr=%h, want 1 f", out_valid, out_payload_instruction);
    end
    step();
`endif
    out_ready = 1'b0;
    tests++;
    if (level !== 3'd0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL stream_end: level=%0d valid=%b, want 0 0", level, out_valid);
    end
  endtask

  task automatic test_full_pop();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hB0 + 32'(i), 32'h0, 32'h0, 3'd0);
      step();
    end
    drive(1'b1, 32'hB4, 32'h0, 32'h0, 3'd0);
    out_ready = 1'b1;
    #1;
    tests++;
    if (cmd_ready !== 1'b0) begin
      fails++;
      $display("FAIL fullpop_ready_comb: cmd_ready=%b, want 0", cmd_ready);
    end
    step();
    out_ready = 1'b0;
    tests++;
    if (cmd_ready !== 1'b1 || level !== 3'd3) begin
      fails++;
      $display("FAIL fullpop_ready: cmd_ready=%b level=%0d, want 1 3", cmd_ready, level);
    end
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 3'd0);
    tests++;
    if (level !== 3'd4 || cmd_ready !== 1'b0) begin
      fails++;
      $display("FAIL fullpop_accept: level=%0d cmd_ready=%b, want 4 0", level, cmd_ready);
    end
    out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tests++;
      if (out_payload_instruction !== 32'hB0 + 32'(i)) begin
        fails++;
        $display("FAIL fullpop_drain[%0d]: instr=%h, want %h", i, out_payload_instruction, 32'hB0 + 32'(i));
      end
      step();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hC0 + 32'(i), 32'h0, 32'h0, 3'd1);
      step();
    end
    drive(1'b0, 32'h0, 32'h0, 32'h0, 3'd0);
    tests++;
    if (level !== 3'd3) begin
      fails++;
      $display("FAIL midrst_pre: level=%0d, want 3", level);
    end
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || level !== 3'd0 || cmd_ready !== 1'b1 || out_payload_instruction !== 32'h0) begin
      fails++;
      $display("FAIL midrst_async: valid=%b level=%0d ready=%b instr=%h, want 0 0 1 0",
               out_valid, level, cmd_ready, out_payload_instruction);
    end
    step();
    #3;
    reset = 1'b1;
    step();
    drive(1'b1, 32'hD0, 32'h0, 32'h0, 3'd0);
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 3'd0);
    tests++;
    if (out_valid !== 1'b1 || level !== 3'd1 || out_payload_instruction !== 32'hD0) begin
      fails++;
      $display("FAIL midrst_after: valid=%b level=%0d instr=%h, want 1 1 d0", out_valid, level, out_payload_instruction);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_latency();
    out_ready = 1'b1;
    drive(1'b1, 32'h0, 32'h55, 32'h0, 3'd0);
    #1;
`ifdef VFU_CMD_FIFO_BYPASS_EN
    tests++;
    if (out_valid !== 1'b1 || out_payload_inputs_0 !== 32'h55) begin
      fails++;
      $display("FAIL bypass_same: valid=%b in0=%h, want 1 55", out_valid, out_payload_inputs_0);
    end
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 3'd0);
    tests++;
    if (level !== 3'd0) begin
      fails++;
      $display("FAIL bypass_level: level=%0d, want 0", level);
    end
`else
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL nobypass_same: valid=%b, want 0", out_valid);
    end
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 3'd0);
    tests++;
    if (out_valid !== 1'b1 || out_payload_inputs_0 !== 32'h55 || level !== 3'd1) begin
      fails++;
      $display("FAIL nobypass_next: valid=%b in0=%h level=%0d, want 1 55 1", out_valid, out_payload_inputs_0, level);
    end
    step();
`endif
    out_ready = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_full_pop();
    test_mid_reset();
    test_latency();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
